// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
//
// Purpose:
//   Single-port-style data memory shared by a CPU (exec state) and a host
//   (idle state). After reset an INIT sequence clears every word, one address
//   per clock, before the memory becomes READY. Reads are combinational so the
//   CPU can latch d_rdata on the same edge it presents d_addr.
//
// Configuration macro:
//   DATA_MEM_STATS_EN - when defined, rd_count/wr_count count CPU loads and
//                       committed CPU stores (saturating). When undefined,
//                       both ports are tied to zero.
//
// Ports:
//   clk        - system clock, all state updates on rising edge
//   reset      - asynchronous active-high reset
//   cpu_state  - 0 = idle (host owns writes), 1 = exec (CPU owns writes)
//   d_addr     - CPU data address
//   d_wdata    - CPU store data
//   d_we       - CPU store strobe
//   d_re       - CPU load strobe (statistics only)
//   d_rdata    - CPU read data, mem[d_addr] in READY, 0 otherwise
//   h_addr     - host address
//   h_wdata    - host write data
//   h_we       - host write strobe
//   h_rdata    - host read data, mem[h_addr] in READY, 0 otherwise
//   init_busy  - high while the clear sequence runs
//   h_err      - one-cycle pulse after a rejected host write
//   rd_count   - CPU load counter
//   wr_count   - CPU store counter
// ---------------------------------------------------------------------------
module data_mem_responder #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_state,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   input  logic              d_we,
   input  logic              d_re,
   output logic [DATA_W-1:0] d_rdata,
   input  logic [ADDR_W-1:0] h_addr,
   input  logic [DATA_W-1:0] h_wdata,
   input  logic              h_we,
   output logic [DATA_W-1:0] h_rdata,
   output logic              init_busy,
   output logic              h_err,
   output logic [15:0]       rd_count,
   output logic [15:0]       wr_count
);

   localparam int DEPTH = 1 << ADDR_W;

   localparam logic [0:0] ST_INIT  = 1'b0;
   localparam logic [0:0] ST_READY = 1'b1;

   localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
   localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

   logic [0:0]        state_r;
   logic [ADDR_W-1:0] clr_ptr_r;
   logic [DATA_W-1:0] mem_r [0:DEPTH-1];
   logic              h_err_r;

   logic              ready_s;
   logic              cpu_wr_s;
   logic              host_wr_s;
   logic              host_rej_s;

   // Write qualification: cpu_state alone decides which side may write.
   always_comb begin
      ready_s    = (state_r == ST_READY);
      cpu_wr_s   = ready_s &  cpu_state & d_we;
      host_wr_s  = ready_s & ~cpu_state & h_we;
      host_rej_s = h_we & ~host_wr_s;
   end

   // INIT/READY state machine and clear pointer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r   <= ST_INIT;
         clr_ptr_r <= '0;
      end else begin
         case (state_r)
            ST_INIT: begin
               clr_ptr_r <= clr_ptr_r + PTR_ONE;
               if (clr_ptr_r == LAST_ADDR) begin
                  state_r <= ST_READY;
               end
            end
            ST_READY: begin
               state_r <= ST_READY;
            end
            default: begin
               state_r   <= ST_INIT;
               clr_ptr_r <= '0;
            end
         endcase
      end
   end

   // Memory array: clear during INIT, otherwise the one permitted writer.
   // Writing zero to mem[0] while reset is held is harmless since INIT
   // rewrites every word anyway.
   always_ff @(posedge clk) begin
      if (state_r == ST_INIT) begin
         mem_r[clr_ptr_r] <= '0;
      end else if (cpu_wr_s) begin
         mem_r[d_addr] <= d_wdata;
      end else if (host_wr_s) begin
         mem_r[h_addr] <= h_wdata;
      end
   end

   // Rejected host write flag, registered so it appears on the next edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         h_err_r <= 1'b0;
      end else begin
         h_err_r <= host_rej_s;
      end
   end

   // Zero-latency read ports; state_r resets asynchronously so both read
   // ports are forced to zero for the whole reset and INIT period.
   always_comb begin
      if (ready_s) begin
         d_rdata = mem_r[d_addr];
         h_rdata = mem_r[h_addr];
      end else begin
         d_rdata = '0;
         h_rdata = '0;
      end
   end

   assign init_busy = (state_r == ST_INIT);
   assign h_err     = h_err_r;

`ifdef DATA_MEM_STATS_EN
   logic [15:0] rd_count_r;
   logic [15:0] wr_count_r;
   logic        cpu_rd_s;

   assign cpu_rd_s = ready_s & cpu_state & d_re;

   // Saturating load/store counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_count_r <= 16'd0;
         wr_count_r <= 16'd0;
      end else begin
         if (cpu_rd_s && (rd_count_r != 16'hFFFF)) begin
            rd_count_r <= rd_count_r + 16'd1;
         end
         if (cpu_wr_s && (wr_count_r != 16'hFFFF)) begin
            wr_count_r <= wr_count_r + 16'd1;
         end
      end
   end

   assign rd_count = rd_count_r;
   assign wr_count = wr_count_r;
`else
   // d_re only feeds the statistics; keep it connected but unused.
   logic stats_unused_s;
   assign stats_unused_s = d_re;
   assign rd_count       = 16'd0;
   assign wr_count       = 16'd0;
`endif

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, word-address width.
REQ-002 SHALL have parameter DATA_W, default 16, data word width; depth is 2^ADDR_W words.
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port cpu_state  input  1  CPU run state: 0 = idle, 1 = exec.
REQ-006 SHALL have port d_addr  input  ADDR_W  CPU data address from the memory stage.
REQ-007 SHALL have port d_wdata  input  DATA_W  CPU store data (the CPU's dataout).
REQ-008 SHALL have port d_we  input  1  CPU store strobe, asserted for a STORE in the memory stage.
REQ-009 SHALL have port d_re  input  1  CPU load strobe, asserted for a LOAD in the memory stage; used for statistics only.
REQ-010 SHALL have port d_rdata  output  DATA_W  read data returned to the CPU (the CPU's datain).
REQ-011 SHALL have port h_addr  input  ADDR_W  host load/inspect address.
REQ-012 SHALL have port h_wdata  input  DATA_W  host write data.
REQ-013 SHALL have port h_we  input  1  host write strobe.
REQ-014 SHALL have port h_rdata  output  DATA_W  host read data.
REQ-015 SHALL have port init_busy  output  1  high while the post-reset clear sequence runs.
REQ-016 SHALL have port h_err  output  1  registered one-cycle pulse flagging a rejected host write.
REQ-017 SHALL have port rd_count  output  16  CPU load counter.
REQ-018 SHALL have port wr_count  output  16  CPU store counter.

Function
REQ-019 SHALL implement a two-state FSM: INIT and READY.
REQ-020 SHALL, in INIT, write 0 to mem[clr_ptr] each cycle and increment clr_ptr (ADDR_W bits).
REQ-021 SHALL move INIT -> READY on the edge that clears address 2^ADDR_W-1; READY has no exit except reset.
REQ-022 SHALL drive init_busy = 1 exactly while in INIT (2^ADDR_W cycles after reset release).
REQ-023 SHALL drive d_rdata = mem[d_addr] combinationally (zero latency) in READY and 0 in INIT, so the CPU latches it on the same edge.
REQ-024 SHALL drive h_rdata = mem[h_addr] combinationally in READY and 0 in INIT.
REQ-025 SHALL commit a CPU write mem[d_addr] <= d_wdata on the rising edge when READY, cpu_state = 1 and d_we = 1.
REQ-026 SHALL commit a host write mem[h_addr] <= h_wdata on the rising edge when READY, cpu_state = 0 and h_we = 1.
REQ-027 SHALL ignore h_we when cpu_state = 1 or in INIT, and pulse h_err high for one cycle on the following edge.
REQ-028 SHALL ignore d_we when cpu_state = 0 or in INIT, with no error indication.
REQ-029 SHALL, for a read of an address written on the same edge, return the old data before the edge and the new data after it (no bypass).
REQ-030 SHALL give CPU and host writes mutual exclusion via cpu_state; no write-port arbitration exists.

Reset
REQ-031 SHALL, on reset assertion, immediately enter INIT with clr_ptr = 0, init_busy = 1, h_err = 0, rd_count = 0, wr_count = 0.
REQ-032 SHALL restart the clear sequence from address 0 when reset is asserted mid-INIT or mid-operation.
REQ-033 SHALL hold d_rdata and h_rdata at 0 throughout reset.

Configuration
REQ-034 SHALL compile access statistics only when macro DATA_MEM_STATS_EN is defined.
REQ-035 SHALL, with DATA_MEM_STATS_EN, increment rd_count on each edge with READY, cpu_state = 1, d_re = 1, and wr_count on each committed CPU write; both saturate at 16'hFFFF.
REQ-036 SHALL, without DATA_MEM_STATS_EN, keep the rd_count and wr_count ports and tie them to 0.

Verification
REQ-037 SHALL cover: preload mem[5] = 16'h1234, release reset -> init_busy high for 256 cycles, then d_addr = 5 reads 16'h0000.
REQ-038 SHALL cover: READY, cpu_state = 1, d_addr = 8'h10, d_wdata = 16'hBEEF, d_we pulse -> next cycle d_rdata = 16'hBEEF at d_addr = 8'h10.
REQ-039 SHALL cover: READY, cpu_state = 0, h_addr = 8'hFF, h_wdata = 16'hA5A5, h_we -> h_rdata = 16'hA5A5; same write with cpu_state = 1 -> memory unchanged, h_err pulses once.
REQ-040 SHALL cover: reset asserted at clr_ptr = 100 -> clr_ptr returns to 0 and init_busy stays high a full 256 cycles after release.
REQ-041 SHALL cover: with DATA_MEM_STATS_EN, 3 loads and 2 stores in exec -> rd_count = 3, wr_count = 2; without the macro -> both 0.
